// File: rtl/audio_adc_rx.sv
// I2S capture receiver for the WM8731 ADC path: oversamples BCLK/LRCK/DAT with clk
// and deserialises MSB-first left/right slots into a parallel sample pair.
module audio_adc_rx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aud_bclk,
    input  logic                  aud_adclrck,
    input  logic                  aud_adcdat,
    output logic [DATA_WIDTH-1:0] ldata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sample_valid,
    output logic                  frame_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;

    logic [2:0]            bclk_sync;
    logic [2:0]            lrck_sync;
    logic [1:0]            dat_sync;
    logic                  bclk_rise;
    logic                  lrck_edge;
    logic                  lrck_now;
    logic                  dat_now;
    state_t                state;
    state_t                start_state;
    logic                  channel;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] hold;
    logic                  left_valid;
    logic                  err_pend;

    // Bit 0 is the first synchronizer stage, bit 1 the second, bit 2 the history flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], aud_bclk};
            lrck_sync <= {lrck_sync[1:0], aud_adclrck};
            dat_sync  <= {dat_sync[0], aud_adcdat};
        end
    end

    assign bclk_rise   = bclk_sync[1] & ~bclk_sync[2];
    assign lrck_edge   = lrck_sync[1] ^ lrck_sync[2];
    assign lrck_now    = lrck_sync[1];
    assign dat_now     = dat_sync[1];
    // A BCLK rise coinciding with the LRCK edge is the delay slot itself.
    assign start_state = bclk_rise ? SHIFT : SKIP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            channel      <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            hold         <= '0;
            left_valid   <= 1'b0;
            ldata        <= '0;
            rdata        <= '0;
            sample_valid <= 1'b0;
            err_pend     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            err_pend     <= 1'b0;
            frame_err    <= err_pend;
            case (state)
                IDLE: begin
                    if (lrck_edge && !lrck_now) begin
                        channel    <= 1'b0;
                        left_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= start_state;
                    end
                end
                SKIP: begin
                    if (lrck_edge) begin
                        channel <= lrck_now;
                        if (!lrck_now)
                            left_valid <= 1'b0;
                        cnt   <= '0;
                        state <= start_state;
                    end else if (bclk_rise) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(DATA_WIDTH)) begin
                        // A right word is only published when its left partner completed.
                        if (!channel) begin
                            hold       <= shreg;
                            left_valid <= 1'b1;
                        end else begin
                            if (left_valid) begin
                                ldata        <= hold;
                                rdata        <= shreg;
                                sample_valid <= 1'b1;
                            end
                            left_valid <= 1'b0;
                        end
                        if (lrck_edge) begin
                            channel <= lrck_now;
                            cnt     <= '0;
                            state   <= start_state;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (lrck_edge) begin
                        err_pend   <= 1'b1;
                        left_valid <= 1'b0;
                        channel    <= lrck_now;
                        cnt        <= '0;
                        state      <= start_state;
                    end else if (bclk_rise) begin
                        shreg <= DATA_WIDTH'({shreg, dat_now});
                        cnt   <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (lrck_edge) begin
                        channel <= lrck_now;
                        if (!lrck_now)
                            left_valid <= 1'b0;
                        cnt   <= '0;
                        state <= start_state;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
